// File: rtl/seg_pkg.sv
// seg_pkg: shared types and constants for the seven-segment mux controller.
//   mux_state_t : display FSM states (blank/show per digit)
//   SEG_OFF     : all segments dark (active-low)
//   SEG_LUT     : hex digit to active-low {g,f,e,d,c,b,a} pattern
//   hex_to_seg  : table lookup helper
package seg_pkg;

   typedef enum logic [1:0] {
      BLANK0 = 2'd0,
      SHOW0  = 2'd1,
      BLANK1 = 2'd2,
      SHOW1  = 2'd3
   } mux_state_t;

   localparam logic [6:0] SEG_OFF = 7'h7F;

   // Index 0 first: 0..9, A, b, C, d, E, F.
   localparam logic [6:0] SEG_LUT [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30,
      7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03,
      7'h46, 7'h21, 7'h06, 7'h0E
   };

   function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
      return SEG_LUT[hex];
   endfunction

endpackage

// File: rtl/seg_decoder.sv
// seg_decoder: combinational hex to seven-segment decoder, active-low outputs.
//   hex : 4-bit digit value
//   seg : segments {g,f,e,d,c,b,a}, 0 = lit
module seg_decoder
   import seg_pkg::*;
(
   input  logic [3:0] hex,
   output logic [6:0] seg
);

   always_comb begin
      seg = hex_to_seg(hex);
   end

endmodule

// File: rtl/seg_mux_ctrl.sv
// seg_mux_ctrl: time-multiplexes one seven-segment decoder across two common-anode digits,
// with a blanking interval before each digit and slot-boundary latching of digit values.
// Also registers the 5-bit sum of both digits for the board LEDs.
//   clk     : system clock
//   reset_n : synchronous active-low reset
//   s0, s1  : hex values for digit 0 / digit 1
//   seg     : segments {g,f,e,d,c,b,a}, active-low, registered
//   an0/an1 : anode enables, active-low, registered, never both low
//   sum     : registered s0 + s1
// Optional build macro SEG_MUX_SYNC_EN: pass s0/s1 through 2-flop synchronizers first.
module seg_mux_ctrl
   import seg_pkg::*;
#(
   parameter int unsigned SHOW_CYCLES  = 23520,
   parameter int unsigned BLANK_CYCLES = 480
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] s0,
   input  logic [3:0] s1,
   output logic [6:0] seg,
   output logic       an0,
   output logic       an1,
   output logic [4:0] sum
);

   localparam int unsigned MaxLen = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
   localparam int unsigned CntW   = $clog2(MaxLen + 1);
   localparam logic [CntW-1:0] ShowLast  = CntW'(SHOW_CYCLES - 1);
   localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);

   // Input conditioning
   logic [3:0] s0_in;
   logic [3:0] s1_in;

`ifdef SEG_MUX_SYNC_EN
   logic [3:0] s0_meta_q, s0_sync_q;
   logic [3:0] s1_meta_q, s1_sync_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         s0_meta_q <= 4'h0;
         s0_sync_q <= 4'h0;
         s1_meta_q <= 4'h0;
         s1_sync_q <= 4'h0;
      end else begin
         s0_meta_q <= s0;
         s0_sync_q <= s0_meta_q;
         s1_meta_q <= s1;
         s1_sync_q <= s1_meta_q;
      end
   end

   assign s0_in = s0_sync_q;
   assign s1_in = s1_sync_q;
`else
   assign s0_in = s0;
   assign s1_in = s1;
`endif

   // State
   mux_state_t      state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [3:0]      d0_q, d0_d;
   logic [3:0]      d1_q, d1_d;
   logic [6:0]      seg_q, seg_d;
   logic            an0_q, an0_d;
   logic            an1_q, an1_d;
   logic [4:0]      sum_q, sum_d;

   logic [3:0] dec_hex;
   logic [6:0] dec_seg;

   // Next state, dwell counter and digit capture
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CntW'(1);
      d0_d    = d0_q;
      d1_d    = d1_q;
      unique case (state_q)
         BLANK0: begin
            if (cnt_q == BlankLast) begin
               state_d = SHOW0;
               d0_d    = s0_in;
            end
         end
         SHOW0: begin
            if (cnt_q == ShowLast) state_d = BLANK1;
         end
         BLANK1: begin
            if (cnt_q == BlankLast) begin
               state_d = SHOW1;
               d1_d    = s1_in;
            end
         end
         SHOW1: begin
            if (cnt_q == ShowLast) state_d = BLANK0;
         end
      endcase
      if (state_d != state_q) cnt_d = '0;
   end

   // Decoder sees the digit about to be shown so segments and anodes switch on the same edge,
   // including a value captured on that very edge.
   assign dec_hex = (state_d == SHOW1) ? d1_d : d0_d;

   seg_decoder u_seg_decoder (
      .hex (dec_hex),
      .seg (dec_seg)
   );

   always_comb begin
      seg_d = SEG_OFF;
      an0_d = 1'b1;
      an1_d = 1'b1;
      unique case (state_d)
         SHOW0: begin
            an0_d = 1'b0;
            seg_d = dec_seg;
         end
         SHOW1: begin
            an1_d = 1'b0;
            seg_d = dec_seg;
         end
         default: begin
            seg_d = SEG_OFF;
         end
      endcase
      sum_d = {1'b0, s0_in} + {1'b0, s1_in};
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= BLANK0;
         cnt_q   <= '0;
         d0_q    <= 4'h0;
         d1_q    <= 4'h0;
         seg_q   <= SEG_OFF;
         an0_q   <= 1'b1;
         an1_q   <= 1'b1;
         sum_q   <= 5'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         d0_q    <= d0_d;
         d1_q    <= d1_d;
         seg_q   <= seg_d;
         an0_q   <= an0_d;
         an1_q   <= an1_d;
         sum_q   <= sum_d;
      end
   end

   assign seg = seg_q;
   assign an0 = an0_q;
   assign an1 = an1_q;
   assign sum = sum_q;

endmodule
